sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Time-multiplexes the single external 16-bit async SRAM between the recorder (write requester)
//  and the DSP (read requester). Generates all SRAM control strobes, owns the DQ tri-state enable
//  and inserts a bus-turnaround cycle after writes. Round-robin when both request.
//  Sits between AudRecorder/AudDSP and the SRAM pins in the top level.
// PARAMETERS
//  ACCESS_CYC  2   cycles per SRAM access (>=2); WE_N/OE_N strobe length
//  AW          20  SRAM address width
// PORTS
//  i_clk          in   1   system clock (all logic on rising edge)
//  i_rst_n        in   1   asynchronous active-low reset
//  i_wr_req       in   1   recorder write request, level, held until o_wr_ack
//  i_wr_addr      in   AW  write address, stable while i_wr_req=1
//  i_wr_data      in   16  write data, stable while i_wr_req=1
//  o_wr_ack       out  1   1-cycle pulse: write completed
//  i_rd_req       in   1   DSP read request, level, held until o_rd_valid
//  i_rd_addr      in   AW  read address, stable while i_rd_req=1
//  o_rd_valid     out  1   1-cycle pulse: o_rd_data valid
//  o_rd_data      out  16  registered read data, holds until next read completes
//  o_sram_addr    out  AW  SRAM address
//  o_sram_dq      out  16  data driven onto DQ when o_sram_dq_oe=1
//  o_sram_dq_oe   out  1   1 = drive DQ (top builds the tri-state)
//  i_sram_dq      in   16  DQ input
//  o_sram_we_n    out  1   write enable, active low
//  o_sram_oe_n    out  1   output enable, active low
//  o_sram_ce_n / o_sram_lb_n / o_sram_ub_n  out 1 each  tied 0 after reset
//  o_busy         out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, last_grant=READ, addr=0, dq=0, dq_oe=0, we_n=1, oe_n=1, ce/lb/ub_n=1,
//   wr_ack=0, rd_valid=0, rd_data=0, cnt=0. After reset ce/lb/ub_n go 0 on first clock.
//   Reset mid-access aborts immediately; no ack/valid for the aborted access.
//  States: IDLE, WRITE, TURN, READ.
//  IDLE: only wr_req -> WRITE; only rd_req -> READ; both -> grant != last_grant (first tie after
//   reset goes to WRITE). Grant latches addr (and data) into output regs at transition; last_grant updated.
//  WRITE: ACCESS_CYC cycles (cnt 0..ACCESS_CYC-1). dq_oe=1 all cycles; we_n=0 for cnt 1..ACCESS_CYC-1,
//   1 at cnt 0 (setup). Last cycle: wr_ack=1, -> TURN.
//  TURN: 1 cycle, dq_oe=0, we_n=1 (DQ released, hold time). -> IDLE. No grant issued from TURN.
//  READ: ACCESS_CYC cycles, oe_n=0, dq_oe=0. Last cycle: rd_data<=i_sram_dq; next cycle rd_valid=1
//   (issued in IDLE), oe_n back to 1. Read latency from grant = ACCESS_CYC+1 cycles.
//  Requester drops req in the cycle after ack/valid; a req still high in IDLE is a new request.
//  Request dropped mid-access: access completes; ack/valid still pulse.
//  dq_oe and oe_n=0 never true in the same cycle; we_n=0 only while dq_oe=1.
//  Address is passed through unmodified (no wrap logic; requesters own addressing).
//  Worst-case service interval with both requesters saturated: 2*ACCESS_CYC+3 cycles per pair.
// TESTING
//  T1 reset: hold i_rst_n=0 -> we_n=oe_n=1, dq_oe=0, wr_ack=rd_valid=0, o_busy=0.
//  T2 single write addr=0x00010 data=0xBEEF, ACCESS_CYC=2 -> we_n low 1 cycle, wr_ack at cycle 2, TURN, IDLE.
//  T3 single read addr=0x00010, SRAM model returns 0xBEEF -> rd_valid 3 cycles after grant, rd_data=0xBEEF.
//  T4 wr_req and rd_req raised same cycle out of reset, held -> grants alternate W,R,W,R; no starvation.
//  T5 assert i_rst_n=0 during WRITE cnt=1 -> we_n=1, dq_oe=0 same cycle; no wr_ack.
//  T6 ACCESS_CYC=4, 64 random mixed accesses vs SRAM model -> all reads match last write; oe/we never overlap.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Arbitrates the single external 16-bit async SRAM between a write requester and a read requester.
// Generates the SRAM strobes, owns the DQ drive enable and inserts a turnaround cycle after writes.
module sram_port_arbiter #(
  parameter int unsigned ACCESS_CYC = 2,
  parameter int unsigned AW         = 20
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_req,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [15:0]   i_wr_data,
  output logic          o_wr_ack,
  input  logic          i_rd_req,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rd_valid,
  output logic [15:0]   o_rd_data,
  output logic [AW-1:0] o_sram_addr,
  output logic [15:0]   o_sram_dq,
  output logic          o_sram_dq_oe,
  input  logic [15:0]   i_sram_dq,
  output logic          o_sram_we_n,
  output logic          o_sram_oe_n,
  output logic          o_sram_ce_n,
  output logic          o_sram_lb_n,
  output logic          o_sram_ub_n,
  output logic          o_busy
);

  localparam int unsigned   CW       = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYC - 1);

  typedef enum logic [1:0] {IDLE, WRITE, TURN, READ} state_e;
  typedef enum logic       {GRANT_READ, GRANT_WRITE} grant_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  grant_e        last_grant_q;
  logic          grant_wr, grant_rd, rd_done, rd_pending;
  logic          ctl_n_q;
  logic          rd_valid_q;
  logic [15:0]   rd_data_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   dq_q;

  // NOTE: async reset in the sensitivity list; every state bit gets <= so all
  // flops update together on the edge, never blocking '=' in clocked logic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The read requester still holds its request during the valid cycle, so a
  // read request seen together with rd_valid is the one just served.
  assign rd_pending = i_rd_req && !rd_valid_q;

  // NOTE: every output of this block is defaulted first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    rd_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_wr_req && rd_pending) begin
          if (last_grant_q == GRANT_READ) grant_wr = 1'b1;
          else                            grant_rd = 1'b1;
        end else if (i_wr_req) begin
          grant_wr = 1'b1;
        end else if (rd_pending) begin
          grant_rd = 1'b1;
        end
        if (grant_wr) begin
          state_d = WRITE;
          cnt_d   = '0;
        end else if (grant_rd) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      WRITE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = TURN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TURN: state_d = IDLE;
      READ: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          rd_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctl_n_q      <= 1'b1;
      last_grant_q <= GRANT_READ;
      addr_q       <= '0;
      dq_q         <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      ctl_n_q    <= 1'b0;
      rd_valid_q <= rd_done;
      if (grant_wr) begin
        addr_q       <= i_wr_addr;
        dq_q         <= i_wr_data;
        last_grant_q <= GRANT_WRITE;
      end
      if (grant_rd) begin
        addr_q       <= i_rd_addr;
        last_grant_q <= GRANT_READ;
      end
      if (rd_done) rd_data_q <= i_sram_dq;
    end
  end

  // Strobes decode straight from the state register so an async reset
  // releases DQ and deasserts WE_N/OE_N in the same cycle.
  assign o_sram_dq_oe = (state_q == WRITE);
  assign o_sram_we_n  = !((state_q == WRITE) && (cnt_q != '0));
  assign o_sram_oe_n  = !(state_q == READ);
  assign o_wr_ack     = (state_q == WRITE) && (cnt_q == CNT_LAST);
  assign o_busy       = (state_q != IDLE);
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_data    = rd_data_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_dq    = dq_q;
  assign o_sram_ce_n  = ctl_n_q;
  assign o_sram_lb_n  = ctl_n_q;
  assign o_sram_ub_n  = ctl_n_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one instance at ACCESS_CYC=2 for timing vectors,
// one at ACCESS_CYC=4 for mixed traffic against a behavioural SRAM and a scoreboard.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        a_wr_req, a_rd_req, a_wr_ack, a_rd_valid, a_dq_oe, a_we_n, a_oe_n;
  logic        a_ce_n, a_lb_n, a_ub_n, a_busy;
  logic [19:0] a_wr_addr, a_rd_addr, a_sram_addr;
  logic [15:0] a_wr_data, a_rd_data, a_sram_dq, a_dq_in;

  logic        b_wr_req, b_rd_req, b_wr_ack, b_rd_valid, b_dq_oe, b_we_n, b_oe_n;
  logic        b_ce_n, b_lb_n, b_ub_n, b_busy;
  logic [19:0] b_wr_addr, b_rd_addr, b_sram_addr;
  logic [15:0] b_wr_data, b_rd_data, b_sram_dq, b_dq_in;

  logic [15:0] a_mem [0:255];
  logic [15:0] b_mem [0:255];
  logic [15:0] exp_mem [0:15];
  logic        mon_en = 1'b0;

  sram_port_arbiter #(.ACCESS_CYC(2), .AW(20)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(a_wr_req), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data), .o_wr_ack(a_wr_ack),
    .i_rd_req(a_rd_req), .i_rd_addr(a_rd_addr), .o_rd_valid(a_rd_valid), .o_rd_data(a_rd_data),
    .o_sram_addr(a_sram_addr), .o_sram_dq(a_sram_dq), .o_sram_dq_oe(a_dq_oe), .i_sram_dq(a_dq_in),
    .o_sram_we_n(a_we_n), .o_sram_oe_n(a_oe_n), .o_sram_ce_n(a_ce_n), .o_sram_lb_n(a_lb_n),
    .o_sram_ub_n(a_ub_n), .o_busy(a_busy)
  );

  sram_port_arbiter #(.ACCESS_CYC(4), .AW(20)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(b_wr_req), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data), .o_wr_ack(b_wr_ack),
    .i_rd_req(b_rd_req), .i_rd_addr(b_rd_addr), .o_rd_valid(b_rd_valid), .o_rd_data(b_rd_data),
    .o_sram_addr(b_sram_addr), .o_sram_dq(b_sram_dq), .o_sram_dq_oe(b_dq_oe), .i_sram_dq(b_dq_in),
    .o_sram_we_n(b_we_n), .o_sram_oe_n(b_oe_n), .o_sram_ce_n(b_ce_n), .o_sram_lb_n(b_lb_n),
    .o_sram_ub_n(b_ub_n), .o_busy(b_busy)
  );

  // Behavioural async SRAMs: write while WE_N low, read data driven while OE_N low.
  always @(posedge clk) begin
    if (!a_we_n && !a_ce_n) a_mem[a_sram_addr[7:0]] <= a_sram_dq;
    if (!b_we_n && !b_ce_n) b_mem[b_sram_addr[7:0]] <= b_sram_dq;
  end
  assign a_dq_in = !a_oe_n ? a_mem[a_sram_addr[7:0]] : 16'h0000;
  assign b_dq_in = !b_oe_n ? b_mem[b_sram_addr[7:0]] : 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // DQ drive and OE_N never overlap; WE_N only low while DQ is driven.
  always @(negedge clk) begin
    if (mon_en) begin
      check("a_strobe_excl", {31'd0, !(a_dq_oe && !a_oe_n) && (a_we_n || a_dq_oe)}, 32'd1);
      check("b_strobe_excl", {31'd0, !(b_dq_oe && !b_oe_n) && (b_we_n || b_dq_oe)}, 32'd1);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic a_read(input logic [19:0] addr, input logic [15:0] exp, input string tag);
    bit got;
    got = 1'b0;
    a_rd_addr = addr;
    a_rd_req  = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      step;
      if (a_rd_valid) begin
        got = 1'b1;
        check(tag, a_rd_data, exp);
      end
    end
    if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
    step;
    a_rd_req = 1'b0;
  endtask

  task automatic b_access(input bit do_wr, input bit do_rd, input logic [19:0] wa,
                          input logic [15:0] wd, input logic [19:0] ra);
    bit wr_done, rd_done, drop_wr, drop_rd;
    logic [15:0] rd_exp;
    rd_exp    = exp_mem[ra[3:0]];
    b_wr_addr = wa;
    b_wr_data = wd;
    b_rd_addr = ra;
    b_wr_req  = do_wr;
    b_rd_req  = do_rd;
    wr_done   = !do_wr;
    rd_done   = !do_rd;
    drop_wr   = 1'b0;
    drop_rd   = 1'b0;
    for (int c = 0; c < 40 && !(wr_done && rd_done && !b_wr_req && !b_rd_req); c++) begin
      step;
      if (drop_wr) begin b_wr_req = 1'b0; drop_wr = 1'b0; end
      if (drop_rd) begin b_rd_req = 1'b0; drop_rd = 1'b0; end
      if (b_wr_ack) begin
        check("t6_spurious_ack", {31'd0, wr_done}, 32'd0);
        wr_done = 1'b1;
        drop_wr = 1'b1;
        exp_mem[wa[3:0]] = wd;
      end
      if (b_rd_valid) begin
        check("t6_spurious_valid", {31'd0, rd_done}, 32'd0);
        check("t6_rd_data", b_rd_data, rd_exp);
        rd_done = 1'b1;
        drop_rd = 1'b1;
      end
    end
    check("t6_complete", {28'd0, wr_done, rd_done, b_wr_req, b_rd_req}, 32'hC);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ev_cyc[$];
    int ev_kind[$];
    int n_ack, n_val;
    logic prev_dq_oe, prev_oe_n;
    logic [19:0] wa, ra;

    rst_n = 1'b0;
    a_wr_req = 1'b0; a_rd_req = 1'b0; a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0;
    b_wr_req = 1'b0; b_rd_req = 1'b0; b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0;

    // T1: reset values, held across clock edges
    #2;
    check("t1_we_n", a_we_n, 1); check("t1_oe_n", a_oe_n, 1); check("t1_dq_oe", a_dq_oe, 0);
    check("t1_wr_ack", a_wr_ack, 0); check("t1_rd_valid", a_rd_valid, 0); check("t1_busy", a_busy, 0);
    check("t1_rd_data", a_rd_data, 0); check("t1_addr", a_sram_addr, 0);
    step; step;
    check("t1_ce_n_in_reset", {a_ce_n, a_lb_n, a_ub_n}, 3'b111);
    rst_n = 1'b1;
    mon_en = 1'b1;
    step;
    check("t1_ce_n_after", {a_ce_n, a_lb_n, a_ub_n}, 3'b000);
    check("t1_idle", a_busy, 0);

    // T2: single write 0x00010 <= 0xBEEF
    a_wr_addr = 20'h00010; a_wr_data = 16'hBEEF; a_wr_req = 1'b1;
    step;
    check("t2_w0_busy", a_busy, 1); check("t2_w0_dq_oe", a_dq_oe, 1); check("t2_w0_we_n", a_we_n, 1);
    check("t2_w0_addr", a_sram_addr, 20'h00010); check("t2_w0_dq", a_sram_dq, 16'hBEEF);
    check("t2_w0_ack", a_wr_ack, 0); check("t2_w0_oe_n", a_oe_n, 1);
    step;
    check("t2_w1_we_n", a_we_n, 0); check("t2_w1_dq_oe", a_dq_oe, 1); check("t2_w1_ack", a_wr_ack, 1);
    step;
    check("t2_turn_dq_oe", a_dq_oe, 0); check("t2_turn_we_n", a_we_n, 1);
    check("t2_turn_ack", a_wr_ack, 0); check("t2_turn_busy", a_busy, 1);
    a_wr_req = 1'b0;
    step;
    check("t2_idle", a_busy, 0);

    // T3: single read 0x00010; request held through the valid cycle
    a_rd_addr = 20'h00010; a_rd_req = 1'b1;
    step;
    check("t3_r0_oe_n", a_oe_n, 0); check("t3_r0_dq_oe", a_dq_oe, 0); check("t3_r0_busy", a_busy, 1);
    check("t3_r0_addr", a_sram_addr, 20'h00010); check("t3_r0_valid", a_rd_valid, 0);
    step;
    check("t3_r1_oe_n", a_oe_n, 0); check("t3_r1_valid", a_rd_valid, 0);
    step;
    check("t3_valid", a_rd_valid, 1); check("t3_data", a_rd_data, 16'hBEEF);
    check("t3_oe_n_off", a_oe_n, 1); check("t3_busy", a_busy, 0);
    step;
    check("t3_no_regrant", a_busy, 0); check("t3_valid_pulse", a_rd_valid, 0);
    check("t3_data_hold", a_rd_data, 16'hBEEF);
    a_rd_req = 1'b0;
    step;

    // T5: reset asserted during WRITE cnt=1 aborts the write
    a_wr_addr = 20'h00010; a_wr_data = 16'hDEAD; a_wr_req = 1'b1;
    step; step;
    check("t5_pre_we_n", a_we_n, 0);
    #1 rst_n = 1'b0;
    #1;
    check("t5_we_n", a_we_n, 1); check("t5_dq_oe", a_dq_oe, 0);
    check("t5_ack", a_wr_ack, 0); check("t5_busy", a_busy, 0);
    a_wr_req = 1'b0;
    step;
    check("t5_ack_held", a_wr_ack, 0);
    rst_n = 1'b1;
    step;
    a_read(20'h00010, 16'hBEEF, "t5_mem_intact");
    step;

    // T4: both requests raised together out of reset and held
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    a_wr_addr = 20'h00020; a_wr_data = 16'h1234; a_wr_req = 1'b1;
    a_rd_addr = 20'h00010; a_rd_req = 1'b1;
    prev_dq_oe = a_dq_oe;
    prev_oe_n  = a_oe_n;
    n_ack = 0;
    n_val = 0;
    for (int c = 1; c <= 30; c++) begin
      step;
      if (a_dq_oe && !prev_dq_oe) begin ev_cyc.push_back(c); ev_kind.push_back(1); end
      if (!a_oe_n && prev_oe_n)   begin ev_cyc.push_back(c); ev_kind.push_back(2); end
      if (a_wr_ack) n_ack++;
      if (a_rd_valid) begin
        n_val++;
        check("t4_rd_data", a_rd_data, 16'hBEEF);
      end
      prev_dq_oe = a_dq_oe;
      prev_oe_n  = a_oe_n;
    end
    a_wr_req = 1'b0;
    a_rd_req = 1'b0;
    check("t4_n_grants", {31'd0, ev_kind.size() >= 4}, 32'd1);
    if (ev_kind.size() >= 4) begin
      check("t4_g0_kind", ev_kind[0], 1); check("t4_g1_kind", ev_kind[1], 2);
      check("t4_g2_kind", ev_kind[2], 1); check("t4_g3_kind", ev_kind[3], 2);
      check("t4_g0_cyc", ev_cyc[0], 1);   check("t4_g1_cyc", ev_cyc[1], 5);
      check("t4_g2_cyc", ev_cyc[2], 8);   check("t4_g3_cyc", ev_cyc[3], 12);
    end
    check("t4_n_ack", n_ack, 5);
    check("t4_n_valid", n_val, 4);
    for (int c = 0; c < 10 && a_busy; c++) step;
    check("t4_drained", a_busy, 0);
    step;
    a_read(20'h00020, 16'h1234, "t4_write_landed");

    // T6: ACCESS_CYC=4 instance, prefill then 48 mixed accesses
    for (int i = 0; i < 16; i++)
      b_access(1'b1, 1'b0, 20'(i), 16'($urandom), 20'd0);
    for (int i = 0; i < 48; i++) begin
      int op;
      op = int'($urandom_range(0, 2));
      wa = 20'($urandom_range(0, 15));
      ra = 20'($urandom_range(0, 15));
      if (op == 2 && ra == wa) ra = ra ^ 20'd1;
      b_access(op != 1, op != 0, wa, 16'($urandom), ra);
    end
    for (int i = 0; i < 16; i++)
      b_access(1'b0, 1'b1, 20'd0, 16'd0, 20'(i));

    step;
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
